// File: rtl/ro_enc_pkg.sv
// ---------------------------------------------------------------------------
// ro_enc_pkg
// Shared definitions for the multi-channel rotary encoder front end:
//   - decode mode codes applied to all channels
//   - direction flag values
//   - transition classification of a filtered {A,B} state change
// ---------------------------------------------------------------------------
package ro_enc_pkg;

    localparam logic [1:0] MODE_X1  = 2'b00;
    localparam logic [1:0] MODE_X2  = 2'b01;
    localparam logic [1:0] MODE_X4  = 2'b10;
    localparam logic [1:0] MODE_OFF = 2'b11;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_CW,
        TR_CCW,
        TR_ILLEGAL
    } trans_e;

    // Classifies one {prev,curr} pair of filtered {A,B} states. A pair where
    // both phases flip at once cannot be attributed to a direction and is
    // reported as illegal; an unchanged state is no transition.
    function automatic trans_e classify(input logic [1:0] prevAb, input logic [1:0] currAb);
        trans_e t;
        t = TR_NONE;
        case ({prevAb, currAb})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: t = TR_CW;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: t = TR_CCW;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: t = TR_ILLEGAL;
            default:                            t = TR_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ro_enc_ch.sv
// ---------------------------------------------------------------------------
// ro_enc_ch
// One encoder channel: 2-FF synchroniser, per-phase glitch filter,
// x1/x2/x4 quadrature decode and a signed saturating step counter with
// direction, pending and sticky error flags.
// Ports:
//   clk_i, rstN_i   clock, asynchronous active-low reset
//   encA_i, encB_i  raw asynchronous phase inputs
//   mode_i          decode mode (MODE_X1/X2/X4/OFF)
//   clear_i         level clear of count, pending and error
//   cnt_o           signed net step count
//   dir_o           direction of last counted step
//   pend_o          a step was counted since the last clear
//   err_o           sticky illegal-transition flag
// ---------------------------------------------------------------------------
module ro_enc_ch
    import ro_enc_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEB_CYC = 16,
    parameter int DEB_W   = 5
) (
    input  logic             clk_i,
    input  logic             rstN_i,
    input  logic             encA_i,
    input  logic             encB_i,
    input  logic [1:0]       mode_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             dir_o,
    output logic             pend_o,
    output logic             err_o
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MIN  = {1'b1, {(CNT_W-1){1'b0}}};

    logic [1:0]            syncAb1_q;
    logic [1:0]            syncAb2_q;
    logic [1:0]            filtAb_q,  filtAb_d;
    logic [1:0][DEB_W-1:0] debCnt_q,  debCnt_d;
    logic [1:0]            prevAb_q,  prevAb_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  dir_q,     dir_d;
    logic                  pend_q,    pend_d;
    logic                  err_q,     err_d;
    trans_e                trans;
    logic                  countable;

    // All channel state lives here. Bit 1 of every {A,B} pair is phase A.
    // The synchroniser stages are plain shift registers; everything else
    // takes its next value from the combinational blocks below.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            syncAb1_q <= '0;
            syncAb2_q <= '0;
            filtAb_q  <= '0;
            debCnt_q  <= '0;
            prevAb_q  <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            syncAb1_q <= {encA_i, encB_i};
            syncAb2_q <= syncAb1_q;
            filtAb_q  <= filtAb_d;
            debCnt_q  <= debCnt_d;
            prevAb_q  <= prevAb_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
        end
    end

    // Glitch filter, one counter per phase. The counter only runs while the
    // synchronised level disagrees with the filtered one, so any agreement
    // restarts the stability window. The filtered level flips on the cycle
    // the counter has already seen DEB_CYC consecutive disagreements.
    always_comb begin
        filtAb_d = filtAb_q;
        debCnt_d = debCnt_q;
        for (int i = 0; i < 2; i++) begin
            if (syncAb2_q[i] == filtAb_q[i]) begin
                debCnt_d[i] = '0;
            end else if (debCnt_q[i] == DEB_LAST) begin
                filtAb_d[i] = syncAb2_q[i];
                debCnt_d[i] = '0;
            end else begin
                debCnt_d[i] = debCnt_q[i] + DEB_W'(1);
            end
        end
    end

    // Transition decode. prevAb_q trails the filtered state by one cycle, so
    // each filtered change is seen exactly once. The mode only gates which
    // transitions count: x1 those leaving 00, x2 those leaving 00 or 11
    // (the legacy detent points), x4 all of them.
    always_comb begin
        trans     = classify(prevAb_q, filtAb_q);
        countable = 1'b0;
        case (mode_i)
            MODE_X1: countable = (prevAb_q == 2'b00);
            MODE_X2: countable = (prevAb_q == 2'b00) || (prevAb_q == 2'b11);
            MODE_X4: countable = 1'b1;
            default: countable = 1'b0;
        endcase
    end

    // Counter and flags. The clear is applied first and the step on top of
    // it, so a step arriving in a clear cycle still lands as +1/-1 with the
    // pending flag set. Saturated steps still report direction and pending.
    // An illegal jump never moves the count but does become the new
    // reference state, so decoding resynchronises on the following edge.
    always_comb begin
        prevAb_d = filtAb_q;
        cnt_d    = clear_i ? '0   : cnt_q;
        pend_d   = clear_i ? 1'b0 : pend_q;
        err_d    = clear_i ? 1'b0 : err_q;
        dir_d    = dir_q;
        if (countable && (trans == TR_CW)) begin
            dir_d  = DIR_CW;
            pend_d = 1'b1;
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end else if (countable && (trans == TR_CCW)) begin
            dir_d  = DIR_CCW;
            pend_d = 1'b1;
            if (cnt_d != CNT_MIN) begin
                cnt_d = cnt_d - CNT_W'(1);
            end
        end
        if (trans == TR_ILLEGAL) begin
            err_d = 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign dir_o  = dir_q;
    assign pend_o = pend_q;
    assign err_o  = err_q;

endmodule

// File: rtl/ro_enc_multi.sv
// ---------------------------------------------------------------------------
// ro_enc_multi
// Multi-channel rotary encoder front end for front-panel encoders. Builds
// CH_NUM independent ro_enc_ch channels and merges their pending flags
// into a single interrupt line.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_ro_enc_state_a/b    raw A/B phases, one bit per channel
//   i_mode                decode mode shared by all channels
//   i_irq_en              per-channel interrupt enable
//   i_sw_intr_clear       per-channel level clear
//   o_ro_enc_cnt          signed counts, channel n at [n*CNT_W +: CNT_W]
//   o_ro_enc_dir/pend/err per-channel direction, pending and error flags
//   o_ro_enc_irq          OR of enabled pending flags (combinational)
// ---------------------------------------------------------------------------
module ro_enc_multi
    import ro_enc_pkg::*;
#(
    parameter int CH_NUM  = 2,
    parameter int CNT_W   = 8,
    parameter int DEB_CYC = 16,
    parameter int DEB_W   = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [CH_NUM-1:0]       i_ro_enc_state_a,
    input  logic [CH_NUM-1:0]       i_ro_enc_state_b,
    input  logic [1:0]              i_mode,
    input  logic [CH_NUM-1:0]       i_irq_en,
    input  logic [CH_NUM-1:0]       i_sw_intr_clear,
    output logic [CH_NUM*CNT_W-1:0] o_ro_enc_cnt,
    output logic [CH_NUM-1:0]       o_ro_enc_dir,
    output logic [CH_NUM-1:0]       o_ro_enc_pend,
    output logic [CH_NUM-1:0]       o_ro_enc_err,
    output logic                    o_ro_enc_irq
);

    // One fully independent channel per encoder; they share only clock,
    // reset and the decode mode.
    for (genvar n = 0; n < CH_NUM; n++) begin : gCh
        ro_enc_ch #(
            .CNT_W   (CNT_W),
            .DEB_CYC (DEB_CYC),
            .DEB_W   (DEB_W)
        ) uCh (
            .clk_i   (i_clk),
            .rstN_i  (i_rst),
            .encA_i  (i_ro_enc_state_a[n]),
            .encB_i  (i_ro_enc_state_b[n]),
            .mode_i  (i_mode),
            .clear_i (i_sw_intr_clear[n]),
            .cnt_o   (o_ro_enc_cnt[n*CNT_W +: CNT_W]),
            .dir_o   (o_ro_enc_dir[n]),
            .pend_o  (o_ro_enc_pend[n]),
            .err_o   (o_ro_enc_err[n])
        );
    end

    // The interrupt follows the flags directly so software sees it drop in
    // the same cycle the clear lands.
    assign o_ro_enc_irq = |(o_ro_enc_pend & i_irq_en);

endmodule

// File: tb/tb_ro_enc_multi.sv
// ---------------------------------------------------------------------------
// tb_ro_enc_multi
// Self-checking bench for ro_enc_multi: a table of single-cycle encoder turns
// in every mode, followed by hand-written sequences for glitch rejection,
// saturation, illegal jumps, clear/step collision timing, channel
// independence and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_ro_enc_multi;
    import ro_enc_pkg::*;

    localparam int CH_NUM  = 2;
    localparam int CNT_W   = 8;
    localparam int DEB_CYC = 16;
    localparam int DEB_W   = 5;
    localparam int HOLD    = 2 * DEB_CYC;
    localparam int FAST    = DEB_CYC + 4;

    logic                    clk = 1'b0;
    logic                    rstN;
    logic [CH_NUM-1:0]       encA;
    logic [CH_NUM-1:0]       encB;
    logic [1:0]              mode;
    logic [CH_NUM-1:0]       irqEn;
    logic [CH_NUM-1:0]       swClr;
    logic [CH_NUM*CNT_W-1:0] cnt;
    logic [CH_NUM-1:0]       encDir;
    logic [CH_NUM-1:0]       encPend;
    logic [CH_NUM-1:0]       encErr;
    logic                    irq;

    typedef struct {
        string name;
        int    ch;
        int    cnt;
        int    dir;
        int    pend;
        int    err;
        int    irq;
        int    otherCnt;
    } expT;

    typedef struct {
        string      name;
        logic [1:0] mode;
        bit         ccw;
        logic [1:0] irqEn;
        int         cnt;
        int         dir;
        int         pend;
        int         err;
        int         irq;
    } vecT;

    expT        expQ[$];
    vecT        vecs[8];
    logic [1:0] cwLev[4]  = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] ccwLev[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int         checks = 0;
    int         passes = 0;

    ro_enc_multi #(
        .CH_NUM  (CH_NUM),
        .CNT_W   (CNT_W),
        .DEB_CYC (DEB_CYC),
        .DEB_W   (DEB_W)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rstN),
        .i_ro_enc_state_a (encA),
        .i_ro_enc_state_b (encB),
        .i_mode           (mode),
        .i_irq_en         (irqEn),
        .i_sw_intr_clear  (swClr),
        .o_ro_enc_cnt     (cnt),
        .o_ro_enc_dir     (encDir),
        .o_ro_enc_pend    (encPend),
        .o_ro_enc_err     (encErr),
        .o_ro_enc_irq     (irq)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic signed [CNT_W-1:0] cntOf(input int ch);
        return cnt[ch*CNT_W +: CNT_W];
    endfunction

    // Advance n clock edges and settle 2 units past the last one, away from
    // the active edge, for both driving and sampling.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [1:0] ab, input int hold);
        encA[ch] = ab[1];
        encB[ch] = ab[0];
        tick(hold);
    endtask

    task automatic turnCycle(input int ch, input bit ccw, input int hold);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ch, ccw ? ccwLev[i] : cwLev[i], hold);
        end
    endtask

    task automatic clearPulse(input logic [CH_NUM-1:0] mask);
        swClr = mask;
        tick(1);
        swClr = '0;
    endtask

    task automatic pushExpect(input string name, input int ch, input int c, input int d,
                              input int p, input int e, input int i, input int oc);
        expT x;
        x.name = name; x.ch = ch; x.cnt = c; x.dir = d;
        x.pend = p; x.err = e; x.irq = i; x.otherCnt = oc;
        expQ.push_back(x);
    endtask

    task automatic popAndCheck();
        expT x;
        if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        x = expQ.pop_front();
        checkOutput({x.name, " cnt"},   int'(cntOf(x.ch)),     x.cnt);
        checkOutput({x.name, " dir"},   int'(encDir[x.ch]),    x.dir);
        checkOutput({x.name, " pend"},  int'(encPend[x.ch]),   x.pend);
        checkOutput({x.name, " err"},   int'(encErr[x.ch]),    x.err);
        checkOutput({x.name, " irq"},   int'(irq),             x.irq);
        checkOutput({x.name, " other"}, int'(cntOf(1 - x.ch)), x.otherCnt);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " cnt"},  int'(cnt),     0);
        checkOutput({name, " dir"},  int'(encDir),  0);
        checkOutput({name, " pend"}, int'(encPend), 0);
        checkOutput({name, " err"},  int'(encErr),  0);
        checkOutput({name, " irq"},  int'(irq),     0);
    endtask

    initial begin
        vecs[0] = '{"x4 cw irq on",  MODE_X4,  1'b0, 2'b01,  4, 0, 1, 0, 1};
        vecs[1] = '{"x4 cw irq off", MODE_X4,  1'b0, 2'b00,  4, 0, 1, 0, 0};
        vecs[2] = '{"x2 ccw",        MODE_X2,  1'b1, 2'b01, -2, 1, 1, 0, 1};
        vecs[3] = '{"x1 ccw",        MODE_X1,  1'b1, 2'b01, -1, 1, 1, 0, 1};
        vecs[4] = '{"x4 ccw",        MODE_X4,  1'b1, 2'b01, -4, 1, 1, 0, 1};
        vecs[5] = '{"off cw",        MODE_OFF, 1'b0, 2'b01,  0, 1, 0, 0, 0};
        vecs[6] = '{"x2 cw",         MODE_X2,  1'b0, 2'b01,  2, 0, 1, 0, 1};
        vecs[7] = '{"x1 cw",         MODE_X1,  1'b0, 2'b01,  1, 0, 1, 0, 1};

        rstN  = 1'b0;
        encA  = '0;
        encB  = '0;
        mode  = MODE_X4;
        irqEn = 2'b01;
        swClr = '0;
        tick(3);
        checkAllZero("reset");
        rstN = 1'b1;
        tick(2);

        // One full quadrature cycle per table entry, starting from a cleared count.
        for (int v = 0; v < 8; v++) begin
            clearPulse(2'b01);
            mode  = vecs[v].mode;
            irqEn = vecs[v].irqEn;
            pushExpect(vecs[v].name, 0, vecs[v].cnt, vecs[v].dir, vecs[v].pend,
                       vecs[v].err, vecs[v].irq, 0);
            turnCycle(0, vecs[v].ccw, HOLD);
            popAndCheck();
        end

        // A pulse one cycle too short for the filter must leave no trace.
        clearPulse(2'b01);
        mode  = MODE_X4;
        irqEn = 2'b01;
        pushExpect("glitch", 0, 0, 0, 0, 0, 0, 0);
        encA[0] = 1'b1;
        tick(DEB_CYC - 1);
        encA[0] = 1'b0;
        tick(HOLD);
        popAndCheck();

        // Saturation at both ends of the signed range.
        clearPulse(2'b01);
        mode = MODE_X1;
        pushExpect("sat max", 0, 127, 0, 1, 0, 1, 0);
        for (int i = 0; i < 130; i++) turnCycle(0, 1'b0, FAST);
        popAndCheck();
        pushExpect("sat max back", 0, 126, 1, 1, 0, 1, 0);
        turnCycle(0, 1'b1, FAST);
        popAndCheck();
        clearPulse(2'b01);
        pushExpect("sat min", 0, -128, 1, 1, 0, 1, 0);
        for (int i = 0; i < 130; i++) turnCycle(0, 1'b1, FAST);
        popAndCheck();

        // Illegal jumps: count frozen, error sticky until cleared.
        clearPulse(2'b01);
        mode = MODE_X4;
        applyStimulus(0, 2'b10, HOLD);
        pushExpect("illegal 10-01", 0, 1, 0, 1, 1, 1, 0);
        applyStimulus(0, 2'b01, HOLD);
        popAndCheck();
        pushExpect("clear after illegal", 0, 0, 0, 0, 0, 0, 0);
        clearPulse(2'b01);
        popAndCheck();
        applyStimulus(0, 2'b00, HOLD);
        clearPulse(2'b01);
        pushExpect("illegal 00-11", 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 2'b11, HOLD);
        popAndCheck();
        pushExpect("illegal sticky", 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 2'b00, HOLD);
        popAndCheck();
        clearPulse(2'b01);
        checkOutput("illegal cleared err", int'(encErr[0]), 0);

        // Clear lands on the exact update edge of a step: the step survives.
        applyStimulus(0, 2'b10, HOLD);
        applyStimulus(0, 2'b11, HOLD);
        checkOutput("pre-collision cnt", int'(cntOf(0)), 2);
        encA[0] = 1'b0;
        encB[0] = 1'b1;
        tick(DEB_CYC + 2);
        checkOutput("collision not early", int'(cntOf(0)), 2);
        swClr = 2'b01;
        tick(1);
        swClr = '0;
        pushExpect("clear+step", 0, 1, 0, 1, 0, 1, 0);
        popAndCheck();
        tick(2);
        checkOutput("clear+step stable", int'(cntOf(0)), 1);

        // Simultaneous steps on both channels; a clear of one spares the other.
        irqEn = 2'b11;
        encA  = 2'b00;
        encB  = 2'b10;
        pushExpect("dual step ch1", 1, -1, 1, 1, 0, 1, 2);
        tick(HOLD);
        popAndCheck();
        pushExpect("ch1 clear only", 1, 0, 1, 0, 0, 1, 2);
        clearPulse(2'b10);
        popAndCheck();

        // Asynchronous reset in the middle of a filter window.
        encB    = 2'b00;
        tick(HOLD);
        encA[0] = 1'b1;
        tick(DEB_CYC / 2 + 2);
        #1;
        rstN = 1'b0;
        #1;
        checkAllZero("async reset");
        encA = '0;
        encB = '0;
        tick(2);
        #3;
        rstN = 1'b1;
        pushExpect("after reset", 0, 0, 0, 0, 0, 0, 0);
        tick(3 * DEB_CYC);
        popAndCheck();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
